// File: rtl/pixel_store_packer.sv
// Packs 8-bit ALU result pixels four per little-endian 32-bit word and writes each
// word to memory via a valid/ack handshake. Optional partial-word flush: PIXEL_STORE_FLUSH_EN.
module pixel_store_packer #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_ack,
`ifdef PIXEL_STORE_FLUSH_EN
  input  logic              flush,
  output logic [3:0]        mem_byte_en,
`endif
  output logic              busy,
  output logic [CNT_W-1:0]  words_written
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t      state_reg;
  logic [1:0]  lane_reg;
  logic [31:0] word_reg;
  logic [31:0] word_next;
  logic        accept;
  logic        do_full;
  logic        do_flush;
  logic [ADDR_W-1:0] aligned_base;

  assign accept       = pix_valid && pix_ready;
  assign do_full      = accept && (lane_reg == 2'd3);
  assign aligned_base = base_addr & ~ADDR_W'(3);

  // Insert the accepted pixel into its byte lane; other lanes keep the partial word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_next[8*gi +: 8] = (accept && (lane_reg == 2'(gi))) ? pix_in : word_reg[8*gi +: 8];
  end

`ifdef PIXEL_STORE_FLUSH_EN
  logic [2:0] fill_cnt;
  logic [3:0] partial_be;
  assign fill_cnt = {1'b0, lane_reg} + {2'b00, accept};
  assign do_flush = flush && (fill_cnt != 3'd0);
  always_comb begin
    partial_be = 4'b0000;
    case (fill_cnt)
      3'd1:    partial_be = 4'b0001;
      3'd2:    partial_be = 4'b0011;
      3'd3:    partial_be = 4'b0111;
      3'd4:    partial_be = 4'b1111;
      default: partial_be = 4'b0000;
    endcase
  end
`else
  assign do_flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      lane_reg      <= 2'd0;
      word_reg      <= '0;
      pix_ready     <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      busy          <= 1'b0;
      words_written <= '0;
`ifdef PIXEL_STORE_FLUSH_EN
      mem_byte_en   <= 4'b0000;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mem_addr      <= aligned_base;
            lane_reg      <= 2'd0;
            word_reg      <= '0;
            words_written <= '0;
            pix_ready     <= 1'b1;
            busy          <= 1'b1;
            state_reg     <= COLLECT;
          end
        end
        COLLECT: begin
          // A restart discards the partial word, including any pixel handed over this cycle.
          if (start) begin
            mem_addr      <= aligned_base;
            lane_reg      <= 2'd0;
            word_reg      <= '0;
            words_written <= '0;
          end else if (do_full || do_flush) begin
            mem_wr_data <= word_next;
            mem_wr_en   <= 1'b1;
            pix_ready   <= 1'b0;
            lane_reg    <= 2'd0;
            word_reg    <= '0;
            state_reg   <= WRITE;
`ifdef PIXEL_STORE_FLUSH_EN
            mem_byte_en <= partial_be;
`endif
          end else if (accept) begin
            word_reg <= word_next;
            lane_reg <= lane_reg + 2'd1;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_addr      <= mem_addr + ADDR_W'(4);
            words_written <= words_written + CNT_W'(1);
            mem_wr_en     <= 1'b0;
            pix_ready     <= 1'b1;
            state_reg     <= COLLECT;
          end
        end
        default: begin
          state_reg <= IDLE;
          pix_ready <= 1'b0;
          mem_wr_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
